// File: rtl/rd_rr_sched.sv
// Round-robin read-path scheduler: picks one non-empty, enabled egress queue,
// offers it with a valid/ready handshake and holds off until the frame is done.

module lzc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    // MODE 0: index of the lowest set bit; otherwise leading-zero count
    if (MODE == 0) begin : g_trailing
        always_comb begin
            cnt_o = '0;
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_W'(i);
            end
        end
    end else begin : g_leading
        always_comb begin
            cnt_o = '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) cnt_o = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

module rd_rr_sched #(
    parameter int unsigned NUM_PORTS = 8,
    parameter int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] port_en_i,
    output logic                 gnt_valid_o,
    input  logic                 gnt_ready_i,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic [NUM_PORTS-1:0] gnt_onehot_o,
    input  logic                 done_i,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_PORTS-1:0] onehot_d;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] masked;
    logic [IDX_W-1:0]     cnt_masked, cnt_elig;
    logic                 empty_masked, empty_elig;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     ptr_wrap;

    assign eligible = req_i & port_en_i;

    // Queues at or above the pointer get first pick
    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            masked[i] = eligible[i] && (i >= int'(ptr_q));
        end
    end

    lzc #(.WIDTH(NUM_PORTS), .MODE(0), .CNT_W(IDX_W)) u_lzc_masked (
        .in_i    (masked),
        .cnt_o   (cnt_masked),
        .empty_o (empty_masked)
    );

    lzc #(.WIDTH(NUM_PORTS), .MODE(0), .CNT_W(IDX_W)) u_lzc_elig (
        .in_i    (eligible),
        .cnt_o   (cnt_elig),
        .empty_o (empty_elig)
    );

    assign winner   = empty_masked ? cnt_elig : cnt_masked;
    assign ptr_wrap = (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + IDX_W'(1);

    // Next-state logic; outputs are registered from the next state
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = '0;
        unique case (state_q)
            IDLE: begin
                if (!empty_elig) begin
                    idx_d   = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (gnt_ready_i) begin
                    ptr_d   = ptr_wrap;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GRANT) onehot_d = NUM_PORTS'(1) << idx_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            gnt_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            gnt_onehot_o <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            gnt_valid_o  <= (state_d == GRANT);
            busy_o       <= (state_d == BUSY);
            gnt_onehot_o <= onehot_d;
        end
    end

    assign gnt_idx_o = idx_q;

endmodule

// File: tb/tb_rd_rr_sched.sv
// Bench for rd_rr_sched: 8-port and 5-port instances share stimulus and are
// compared every cycle against a round-robin reference model.

module tb_rd_rr_sched;

    logic       clk = 1'b0;
    logic       rst, ready, done;
    logic [7:0] req, en;

    logic       v8, b8, v5, b5;
    logic [2:0] idx8, idx5;
    logic [7:0] oh8;
    logic [4:0] oh5;

    int vectors     = 0;
    int miscompares = 0;

    int m_st[2];
    int m_ptr[2];
    int m_idx[2];
    int n_of[2] = '{8, 5};
    int log8[$];
    int log5[$];

    always #5 clk = ~clk;

    rd_rr_sched #(.NUM_PORTS(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .port_en_i(en),
        .gnt_valid_o(v8), .gnt_ready_i(ready), .gnt_idx_o(idx8),
        .gnt_onehot_o(oh8), .done_i(done), .busy_o(b8)
    );

    rd_rr_sched #(.NUM_PORTS(5)) dut5 (
        .clk_i(clk), .rst_i(rst), .req_i(req[4:0]), .port_en_i(en[4:0]),
        .gnt_valid_o(v5), .gnt_ready_i(ready), .gnt_idx_o(idx5),
        .gnt_onehot_o(oh5), .done_i(done), .busy_o(b5)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next queue at or after the pointer, scanning circularly
    function automatic int pick(input int k, input int elig);
        for (int o = 0; o < n_of[k]; o++) begin
            int p;
            p = (m_ptr[k] + o) % n_of[k];
            if (elig[p]) return p;
        end
        return -1;
    endfunction

    function automatic int at8(input int i);
        return (i < log8.size()) ? log8[i] : -1;
    endfunction

    function automatic int at5(input int i);
        return (i < log5.size()) ? log5[i] : -1;
    endfunction

    task automatic step();
        logic       r, rd, dn;
        logic [7:0] rq, e;
        r = rst; rd = ready; dn = done; rq = req; e = en;
        if (!r && v8 && rd) log8.push_back(int'(idx8));
        if (!r && v5 && rd) log5.push_back(int'(idx5));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int el;
            el = int'(rq & e) & ((1 << n_of[k]) - 1);
            if (r) begin
                m_st[k] = 0; m_ptr[k] = 0; m_idx[k] = 0;
            end else begin
                case (m_st[k])
                    0: if (el != 0) begin m_idx[k] = pick(k, el); m_st[k] = 1; end
                    1: if (rd) begin m_ptr[k] = (m_idx[k] + 1) % n_of[k]; m_st[k] = 2; end
                    default: if (dn) m_st[k] = 0;
                endcase
            end
        end
        #1;
        chk("valid8",  int'(v8),   int'(m_st[0] == 1));
        chk("busy8",   int'(b8),   int'(m_st[0] == 2));
        chk("idx8",    int'(idx8), m_idx[0]);
        chk("onehot8", int'(oh8),  (m_st[0] == 1) ? (1 << m_idx[0]) : 0);
        chk("valid5",  int'(v5),   int'(m_st[1] == 1));
        chk("busy5",   int'(b5),   int'(m_st[1] == 2));
        chk("idx5",    int'(idx5), m_idx[1]);
        chk("onehot5", int'(oh5),  (m_st[1] == 1) ? (1 << m_idx[1]) : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_log8(input int cnt);
        int i;
        i = 0;
        while (log8.size() < cnt && i < 40) begin step(); i++; end
        if (log8.size() < cnt) chk("timeout8", log8.size(), cnt);
    endtask

    task automatic wait_log5(input int cnt);
        int i;
        i = 0;
        while (log5.size() < cnt && i < 40) begin step(); i++; end
        if (log5.size() < cnt) chk("timeout5", log5.size(), cnt);
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; done = 1'b0; req = '0; en = 8'hFF;

        // Reset state
        do_reset();
        chk("rst_valid", int'(v8), 0);
        chk("rst_onehot", int'(oh8), 0);

        // Basic rotation over 2,5,7
        req = 8'hA4; ready = 1'b1; done = 1'b1; log8.delete();
        wait_log8(4);
        chk("rot_g0", at8(0), 2);
        chk("rot_g1", at8(1), 5);
        chk("rot_g2", at8(2), 7);
        chk("rot_g3", at8(3), 2);

        // Wrap from 6 to 0
        do_reset();
        req = 8'h40; log8.delete();
        wait_log8(1);
        chk("wrap_first", at8(0), 6);
        req = 8'h41; log8.delete();
        wait_log8(2);
        chk("wrap_g0", at8(0), 0);
        chk("wrap_g1", at8(1), 6);

        // Grant held while ready is low and the request drops
        do_reset();
        ready = 1'b0; req = 8'h08;
        for (int i = 0; i < 10 && !v8; i++) step();
        chk("hold_valid", int'(v8), 1);
        req = 8'h00;
        repeat (5) begin
            step();
            chk("hold_v", int'(v8), 1);
            chk("hold_idx", int'(idx8), 3);
        end
        ready = 1'b1; log8.delete();
        step();
        chk("hold_acc", at8(0), 3);
        chk("hold_busy", int'(b8), 1);

        // Enable mask restricts grants to queue 4; empty mask never grants
        do_reset();
        req = 8'hFF; en = 8'h10; log8.delete(); log5.delete();
        repeat (15) step();
        chk("mask_cnt", int'(log8.size() >= 3), 1);
        foreach (log8[i]) chk("mask_idx8", log8[i], 4);
        foreach (log5[i]) chk("mask_idx5", log5[i], 4);
        en = 8'h00;
        repeat (4) step();
        repeat (10) begin
            step();
            chk("mask_none", int'(v8), 0);
        end
        en = 8'hFF;

        // Reset while busy aborts without a pointer update
        do_reset();
        req = 8'h20; done = 1'b0; log8.delete();
        wait_log8(1);
        chk("abort_g", at8(0), 5);
        chk("abort_busy", int'(b8), 1);
        rst = 1'b1;
        step();
        chk("abort_v", int'(v8), 0);
        chk("abort_b", int'(b8), 0);
        chk("abort_idx", int'(idx8), 0);
        chk("abort_oh", int'(oh8), 0);
        rst = 1'b0; req = 8'h21; done = 1'b1; log8.delete();
        wait_log8(1);
        chk("abort_next", at8(0), 0);

        // Five-port wrap: 0,4,0 alternate
        do_reset();
        req = 8'h11; log5.delete(); log8.delete();
        wait_log5(3);
        chk("p5_g0", at5(0), 0);
        chk("p5_g1", at5(1), 4);
        chk("p5_g2", at5(2), 0);
        chk("p8_g1", at8(1), 4);

        // Random traffic against the model
        repeat (600) begin
            req   = 8'($urandom);
            en    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            ready = 1'($urandom_range(0, 1));
            done  = 1'($urandom_range(0, 1));
            rst   = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rd_rr_sched.md
RD_RR_SCHED -- requirements
Module: rd_rr_sched

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8, meaning number of egress queues competing for the read path; legal range 1..32.
REQ-002 SHALL have parameter IDX_W, default (NUM_PORTS>1 ? clog2(NUM_PORTS) : 1), meaning width of the grant index.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  NUM_PORTS  per-queue non-empty flags; bit n = queue n has a frame.
REQ-006 SHALL have port port_en_i  input  NUM_PORTS  per-queue enable mask; a disabled queue is never granted.
REQ-007 SHALL have port gnt_valid_o  output  1  grant offered.
REQ-008 SHALL have port gnt_ready_i  input  1  read engine accepts the grant.
REQ-009 SHALL have port gnt_idx_o  output  IDX_W  binary index of the granted queue.
REQ-010 SHALL have port gnt_onehot_o  output  NUM_PORTS  one-hot form of gnt_idx_o; all-zero when gnt_valid_o=0.
REQ-011 SHALL have port done_i  input  1  read engine has finished the frame of the accepted grant.
REQ-012 SHALL have port busy_o  output  1  a grant is accepted and its frame is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, BUSY.
REQ-014 SHALL form eligible = req_i & port_en_i, sampled only in IDLE.
REQ-015 SHALL form masked = eligible with bits below ptr cleared; winner = lowest set index of masked if masked!=0, else lowest set index of eligible (instantiate lzc, MODE=0, twice; empty_o selects).
REQ-016 IDLE: if eligible!=0, register winner into gnt_idx_o and go to GRANT; otherwise stay IDLE. Latency from req_i rising to gnt_valid_o = 1 cycle.
REQ-017 GRANT: gnt_valid_o=1; gnt_idx_o/gnt_onehot_o held stable until handshake, regardless of req_i/port_en_i changes (no withdrawal).
REQ-018 Handshake = gnt_valid_o & gnt_ready_i; on handshake go to BUSY and set ptr = gnt_idx_o+1, wrapping to 0 when gnt_idx_o = NUM_PORTS-1.
REQ-019 BUSY: busy_o=1, gnt_valid_o=0; on done_i go to IDLE. done_i in IDLE or GRANT SHALL be ignored.
REQ-020 done_i in BUSY with eligible!=0 SHALL give exactly one IDLE cycle before the next GRANT (back-to-back grant period = 3 cycles minimum with ready tied high and done_i one cycle after handshake).
REQ-021 ptr SHALL be IDX_W bits and only take values 0..NUM_PORTS-1; ptr changes only on handshake.
REQ-022 For NUM_PORTS=1: gnt_idx_o constant 0; FSM behaviour otherwise identical.
REQ-023 gnt_valid_o, busy_o, gnt_onehot_o SHALL be registered outputs or direct decodes of registered state (no combinational path from req_i/gnt_ready_i to outputs).

Reset
REQ-024 While rst_i=1 at a clock edge: state=IDLE, ptr=0, gnt_valid_o=0, gnt_idx_o=0, gnt_onehot_o=0, busy_o=0.
REQ-025 rst_i in GRANT or BUSY SHALL abort the grant with no pointer update; first grant after reset uses ptr=0.

Verification
REQ-026 NUM_PORTS=8, after reset req_i=8'b1010_0100, en all 1, ready=1 -> grants in order 2,5,7,2 (done_i one cycle after each handshake).
REQ-027 Grant idx 6 accepted, then req_i=8'b0100_0001 -> next grant 0 (wrap), then 6.
REQ-028 GRANT on idx 3 with gnt_ready_i=0 for 5 cycles while req_i drops to 0 -> gnt_valid_o stays 1, gnt_idx_o stays 3, accepted on cycle 6.
REQ-029 req_i=8'hFF, port_en_i=8'b0001_0000 -> every grant is 4; port_en_i=0 -> gnt_valid_o never asserts.
REQ-030 rst_i asserted in BUSY after grant 5 -> next cycle all outputs 0; with req_i=8'b0010_0001 first grant is 0.
REQ-031 NUM_PORTS=5, ptr after grant 4 wraps to 0; req_i=5'b1_0001 -> grants 0,4,0 alternate.
